// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage hookup of the iterative divide/multiply unit.
//   ex_aluOp/ex_reg1/ex_reg2 : operation and operands from the ID/EX register
//   cancel                   : pipeline flush, aborts the operation in flight
//   stallreq                 : freeze request towards the pipeline controller
//   ready_o/hi_o/lo_o        : one-cycle result strobe and the HI/LO result
// Modports: master = EX/pipeline side, slave = ex_muldiv.
interface ex_muldiv_if #(
  parameter int DATA_W = 32
);
  logic [7:0]        ex_aluOp;
  logic [DATA_W-1:0] ex_reg1;
  logic [DATA_W-1:0] ex_reg2;
  logic              cancel;
  logic              stallreq;
  logic              ready_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;

  modport master (
    output ex_aluOp, ex_reg1, ex_reg2, cancel,
    input  stallreq, ready_o, hi_o, lo_o
  );

  modport slave (
    input  ex_aluOp, ex_reg1, ex_reg2, cancel,
    output stallreq, ready_o, hi_o, lo_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative restoring divider (DIV/DIVU) for the EX stage, one
// quotient bit per cycle over DATA_W cycles. Divide by zero short-cuts
// through DIVZERO (lo = all ones, hi = dividend unmodified).
// Optional macro MULDIV_MULT_EN adds MULT/MULTU as a shift-add multiplier
// with the same latency; without it those ops are ignored.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset
//   bus  : ex_muldiv_if.slave (op/operands/cancel in, stallreq/ready_o/hi_o/lo_o out)
//
// state   | meaning
// IDLE    | waiting for a supported op
// DIVZERO | divisor was zero, result is forced
// CALC    | one divide/multiply step per cycle
// DONE    | ready_o high, hi_o/lo_o hold the new result
`ifndef EXE_MULT_OP
`define EXE_MULT_OP  8'b00011000
`endif
`ifndef EXE_MULTU_OP
`define EXE_MULTU_OP 8'b00011001
`endif
`ifndef EXE_DIV_OP
`define EXE_DIV_OP   8'b00011010
`endif
`ifndef EXE_DIVU_OP
`define EXE_DIVU_OP  8'b00011011
`endif

module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, DIVZERO, CALC, DONE} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;   // partial remainder (div) / upper product (mult)
  logic [DATA_W-1:0] quo;   // dividend->quotient (div) / multiplier->lower product
  logic [DATA_W-1:0] op_b;
  logic              neg_q;
  logic              neg_r;
`ifdef MULDIV_MULT_EN
  logic              mult_mode;
`endif

  logic              is_div_op, is_signed_op, is_op, start, last_step;
  logic [DATA_W-1:0] abs_a, abs_b;
  logic [DATA_W:0]   shifted, diff;
  logic [DATA_W-1:0] step_acc, step_quo, res_hi, res_lo;
`ifdef MULDIV_MULT_EN
  logic [DATA_W:0]   sum;
  logic [2*DATA_W-1:0] prod;
`endif

  always_comb begin
    is_div_op    = (bus.ex_aluOp == `EXE_DIV_OP) || (bus.ex_aluOp == `EXE_DIVU_OP);
    is_signed_op = (bus.ex_aluOp == `EXE_DIV_OP);
    is_op        = is_div_op;
`ifdef MULDIV_MULT_EN
    is_signed_op = is_signed_op || (bus.ex_aluOp == `EXE_MULT_OP);
    is_op        = is_op || (bus.ex_aluOp == `EXE_MULT_OP) || (bus.ex_aluOp == `EXE_MULTU_OP);
`endif
    start     = (state == IDLE) && !bus.cancel && is_op;
    abs_a     = (is_signed_op && bus.ex_reg1[DATA_W-1]) ? -bus.ex_reg1 : bus.ex_reg1;
    abs_b     = (is_signed_op && bus.ex_reg2[DATA_W-1]) ? -bus.ex_reg2 : bus.ex_reg2;
    last_step = (cnt == CNT_W'(DATA_W-1));
  end

  // One datapath step; the final sign fix-up is applied to the last step's result.
  always_comb begin
    shifted = {acc, quo[DATA_W-1]};
    diff    = shifted - {1'b0, op_b};
    if (!diff[DATA_W]) begin
      step_acc = diff[DATA_W-1:0];
      step_quo = {quo[DATA_W-2:0], 1'b1};
    end else begin
      step_acc = shifted[DATA_W-1:0];
      step_quo = {quo[DATA_W-2:0], 1'b0};
    end
    res_lo = neg_q ? -step_quo : step_quo;
    res_hi = neg_r ? -step_acc : step_acc;
`ifdef MULDIV_MULT_EN
    sum  = {1'b0, acc} + (quo[0] ? {1'b0, op_b} : '0);
    prod = '0;
    if (mult_mode) begin
      step_acc = sum[DATA_W:1];
      step_quo = {sum[0], quo[DATA_W-1:1]};
      prod     = {step_acc, step_quo};
      if (neg_q) prod = -prod;
      res_hi   = prod[2*DATA_W-1:DATA_W];
      res_lo   = prod[DATA_W-1:0];
    end
`endif
  end

  always_comb begin
    state_nxt    = state;
    bus.stallreq = 1'b0;
    if (bus.cancel) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          bus.stallreq = start;
          if (start) state_nxt = (is_div_op && bus.ex_reg2 == '0) ? DIVZERO : CALC;
        end
        DIVZERO: begin
          bus.stallreq = 1'b1;
          state_nxt    = DONE;
        end
        CALC: begin
          bus.stallreq = 1'b1;
          if (last_step) state_nxt = DONE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      quo         <= '0;
      op_b        <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
`ifdef MULDIV_MULT_EN
      mult_mode   <= 1'b0;
`endif
      bus.ready_o <= 1'b0;
      bus.hi_o    <= '0;
      bus.lo_o    <= '0;
    end else begin
      state       <= state_nxt;
      bus.ready_o <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            // divide by zero keeps the raw dividend in acc for hi_o
            acc       <= (is_div_op && bus.ex_reg2 == '0) ? bus.ex_reg1 : '0;
            quo       <= abs_a;
            op_b      <= abs_b;
            cnt       <= '0;
            neg_q     <= is_signed_op && (bus.ex_reg1[DATA_W-1] ^ bus.ex_reg2[DATA_W-1]);
            neg_r     <= is_signed_op && bus.ex_reg1[DATA_W-1];
`ifdef MULDIV_MULT_EN
            mult_mode <= !is_div_op;
`endif
          end
        end
        CALC: begin
          if (!bus.cancel) begin
            acc <= step_acc;
            quo <= step_quo;
            cnt <= cnt + 1'b1;
            if (last_step) begin
              bus.hi_o <= res_hi;
              bus.lo_o <= res_lo;
            end
          end
        end
        DIVZERO: begin
          if (!bus.cancel) begin
            bus.hi_o <= acc;
            bus.lo_o <= '1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed bench for ex_muldiv. Inputs change 1 time unit
// after the rising edge, outputs are sampled on the falling edge.
module tb_ex_muldiv;
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [31:0] last_hi, last_lo;

  ex_muldiv_if #(.DATA_W(32)) bus ();

  ex_muldiv #(.DATA_W(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Drives one op, checks stall during the busy cycles and the result on the
  // ready cycle; returns at the start of the cycle after ready (IDLE).
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] ehi, input logic [31:0] elo);
    bus.ex_aluOp = op;
    bus.ex_reg1  = a;
    bus.ex_reg2  = b;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      check({tag, " stallreq busy"}, {63'd0, bus.stallreq}, 64'd1);
      check({tag, " ready busy"}, {63'd0, bus.ready_o}, 64'd0);
      if (i == 0) begin
        check({tag, " hi held"}, {32'd0, bus.hi_o}, {32'd0, last_hi});
        check({tag, " lo held"}, {32'd0, bus.lo_o}, {32'd0, last_lo});
      end
      next_cycle();
    end
    @(negedge clk);
    check({tag, " ready"}, {63'd0, bus.ready_o}, 64'd1);
    check({tag, " stallreq done"}, {63'd0, bus.stallreq}, 64'd0);
    check({tag, " hi"}, {32'd0, bus.hi_o}, {32'd0, ehi});
    check({tag, " lo"}, {32'd0, bus.lo_o}, {32'd0, elo});
    bus.ex_aluOp = OP_NOP;
    last_hi = ehi;
    last_lo = elo;
    next_cycle();
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, " idle ready"}, {63'd0, bus.ready_o}, 64'd0);
    check({tag, " idle stallreq"}, {63'd0, bus.stallreq}, 64'd0);
    check({tag, " idle hi"}, {32'd0, bus.hi_o}, {32'd0, last_hi});
    check({tag, " idle lo"}, {32'd0, bus.lo_o}, {32'd0, last_lo});
    next_cycle();
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    last_hi      = 32'd0;
    last_lo      = 32'd0;
    rst          = 1'b0;
    bus.ex_aluOp = OP_DIVU;
    bus.ex_reg1  = 32'd100;
    bus.ex_reg2  = 32'd7;
    bus.cancel   = 1'b0;

    // reset beats a pending op
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("reset ready", {63'd0, bus.ready_o}, 64'd0);
    check("reset hi", {32'd0, bus.hi_o}, 64'd0);
    check("reset lo", {32'd0, bus.lo_o}, 64'd0);
    bus.ex_aluOp = OP_NOP;
    next_cycle();
    rst = 1'b1;
    idle_check("post reset");

    run_op("divu 100/7", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    idle_check("divu 100/7");

    run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // back-to-back: next op starts in the IDLE cycle right after DONE
    run_op("div min/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'd1, 32'hFFFF_FFFD);
    run_op("divu max/16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 33, 32'hF, 32'h0FFF_FFFF);
    idle_check("divu max/16");

    run_op("divu 5/0", OP_DIVU, 32'd5, 32'd0, 2, 32'd5, 32'hFFFF_FFFF);
    idle_check("divu 5/0");
    run_op("div -5/0", OP_DIV, 32'hFFFF_FFFB, 32'd0, 2, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    idle_check("div -5/0");

    // cancel at T+10 with the op still presented
    bus.ex_aluOp = OP_DIV;
    bus.ex_reg1  = 32'hFFFF_FF9C;
    bus.ex_reg2  = 32'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("cancel pre stallreq", {63'd0, bus.stallreq}, 64'd1);
      next_cycle();
    end
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel stallreq", {63'd0, bus.stallreq}, 64'd0);
    check("cancel ready", {63'd0, bus.ready_o}, 64'd0);
    next_cycle();
    bus.cancel   = 1'b0;
    bus.ex_aluOp = OP_NOP;
    for (int i = 0; i < 30; i++) idle_check("after cancel");
    run_op("divu 9/3", OP_DIVU, 32'd9, 32'd3, 33, 32'd0, 32'd3);

    // reset in the middle of a divide
    bus.ex_aluOp = OP_DIV;
    bus.ex_reg1  = 32'd1000;
    bus.ex_reg2  = 32'd3;
    for (int i = 0; i < 5; i++) next_cycle();
    rst          = 1'b0;
    bus.ex_aluOp = OP_NOP;
    next_cycle();
    rst = 1'b1;
    last_hi = 32'd0;
    last_lo = 32'd0;
    for (int i = 0; i < 30; i++) idle_check("after mid reset");
    run_op("divu 100/7 again", OP_DIVU, 32'd100, 32'd7, 33, 32'd2, 32'd14);

`ifdef MULDIV_MULT_EN
    run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu max*2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 33, 32'd1, 32'hFFFF_FFFE);
    run_op("mult min*min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0);
    idle_check("mult");
`else
    bus.ex_aluOp = OP_MULT;
    bus.ex_reg1  = 32'hFFFF_FFFD;
    bus.ex_reg2  = 32'd5;
    for (int i = 0; i < 40; i++) idle_check("mult ignored");
    bus.ex_aluOp = OP_MULTU;
    for (int i = 0; i < 5; i++) idle_check("multu ignored");
    bus.ex_aluOp = OP_NOP;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
